mux_scan_n: RTL

- Parametrised, registered N-channel, W-bit multiplexer; generation after the combinational 32:1 single-bit mux.
- Two modes:
  - Manual: select comes from a port.
  - Scan: an internal pointer round-robins over mask-enabled channels.
- Output is held in a valid/ready register stage, so it feeds downstream consumers (UART/packetizer, logger) without losing samples.

---
 rtl/mux_scan_n.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mux_scan_n.sv
// mux_scan_n: registered N-channel, W-bit multiplexer with a valid/ready
// output stage. Manual mode selects from the sel port; scan mode
// round-robins an internal pointer over the channels enabled in mask.
module mux_scan_n #(
  parameter int N     = 32,
  parameter int W     = 1,
  parameter int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [N*W-1:0]   in,
  input  logic [SEL_W-1:0] sel,
  input  logic             mode,
  input  logic [N-1:0]     mask,
  output logic [W-1:0]     out,
  output logic [SEL_W-1:0] out_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             last,
  output logic             err
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [N-1:0][W-1:0] ch;
  logic [SEL_W-1:0]    ptr;

  logic                scan_hit;
  logic                scan_last;
  logic [SEL_W-1:0]    scan_k;
  logic [SEL_W-1:0]    ptr_nxt;

  logic                man_ok;
  logic [W-1:0]        man_d;

  logic                cap;
  logic [W-1:0]        d_nxt;
  logic [SEL_W-1:0]    ch_nxt;
  logic                last_nxt;
  logic                err_nxt;

  // Channel k lives at in[k*W +: W]; the packed view lets us index by channel.
  assign ch = in;

  // Rotate-priority search: first enabled channel at or after ptr (mod N),
  // plus the highest enabled channel so the end of a pass can be flagged.
  always_comb begin
    int j, k, hi;
    scan_hit = 1'b0;
    j  = 0;
    k  = 0;
    hi = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!scan_hit && mask[SEL_W'(j)]) begin
        scan_hit = 1'b1;
        k        = j;
      end
      if (mask[SEL_W'(i)]) hi = i;
    end
    scan_k    = SEL_W'(k);
    scan_last = (k == hi);
    ptr_nxt   = (k == N - 1) ? '0 : SEL_W'(k + 1);
  end

  // Manual select; out-of-range sel (only possible for non power-of-2 N)
  // yields zero data and raises err.
  always_comb begin
    man_ok = (int'(sel) < N);
    man_d  = man_ok ? ch[sel] : '0;
  end

  // Capture decision and the sample that would be loaded this edge.
  // An empty mask in scan mode behaves as if ena were low.
  always_comb begin
    cap      = ena & (~out_valid | out_ready) & (~mode | scan_hit);
    d_nxt    = man_d;
    ch_nxt   = sel;
    last_nxt = 1'b0;
    err_nxt  = ~man_ok;
    if (mode) begin
      d_nxt    = ch[scan_k];
      ch_nxt   = scan_k;
      last_nxt = scan_last;
      err_nxt  = 1'b0;
    end
  end

  // Output-stage occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Occupancy next-state: fill on capture, drain on accept without refill.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (cap) state_nxt = FULL;
      FULL:    if (cap) state_nxt = FULL;
               else if (out_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  assign out_valid = (state == FULL);

  // Sample registers and scan pointer; everything holds unless a capture
  // occurs, so a stalled sample is never overwritten. Manual captures leave
  // ptr alone so scanning resumes where it left off.
  always_ff @(posedge clk) begin
    if (rst) begin
      out    <= '0;
      out_ch <= '0;
      last   <= 1'b0;
      err    <= 1'b0;
      ptr    <= '0;
    end else if (cap) begin
      out    <= d_nxt;
      out_ch <= ch_nxt;
      last   <= last_nxt;
      err    <= err_nxt;
      if (mode) ptr <= ptr_nxt;
    end
  end

endmodule
